dcache_controller: RTL and testbench

//  Data-cache responder to the core's MemRead/MemWrite strobes from the control unit. Sits between the single-cycle datapath and main memory.

---
 rtl/dcache_pkg.sv | 18 +
 rtl/dcache_array.sv | 62 ++++++
 rtl/dcache_controller.sv | 145 ++++++++++++++
 tb/tb_dcache_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants for the direct-mapped write-through data cache:
// FSM state encoding plus default and derived geometry.
package dcache_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 32;
    localparam int INDEX_W_DEF  = 5;
    localparam int OFFSET_W_DEF = 2;

    localparam int TAG_W   = ADDR_W_DEF - INDEX_W_DEF - OFFSET_W_DEF;
    localparam int N_WORDS = 1 << OFFSET_W_DEF;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR_WAIT  = 2'd1;
    localparam logic [1:0] ST_FILL_REQ = 2'd2;
    localparam logic [1:0] ST_FILL     = 2'd3;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the data cache. One combinational read port
// on the request index, one word-write port shared by fills and write hits.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int TAG_BITS = TAG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                fill_done,
    input  logic [TAG_BITS-1:0] fill_tag
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    valid_set;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES*WORDS];

    // One-hot set mask for the line completing its fill
    for (genvar gi = 0; gi < LINES; gi++) begin : g_vset
        assign valid_set[gi] = fill_done && (wr_index == INDEX_W'(gi));
    end

    // Valid bits: cleared together on reset, set when a fill completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_q | valid_set;
        end
    end

    // Tag and data storage; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[wr_index] <= fill_tag;
        end
        if (wr_en) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits answer in the same cycle; misses and every store stall the core
// until main memory has granted the write or delivered the whole block.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              mm_req,
    output logic              mm_we,
    output logic [ADDR_W-1:0] mm_addr,
    output logic [DATA_W-1:0] mm_wdata,
    input  logic              mm_gnt,
    input  logic              mm_rvalid,
    input  logic [DATA_W-1:0] mm_rdata
);

    localparam int TAG_BITS = ADDR_W - INDEX_W - OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_WORD = '1;

    logic [TAG_BITS-1:0] addr_tag;
    logic [INDEX_W-1:0]  addr_index;
    logic [OFFSET_W-1:0] addr_offset;

    logic [1:0]          state_q, state_d;
    logic [OFFSET_W-1:0] fill_cnt_q, fill_cnt_d;

    logic                line_valid;
    logic [TAG_BITS-1:0] line_tag;
    logic [DATA_W-1:0]   line_data;
    logic                hit;

    logic                wr_en;
    logic [OFFSET_W-1:0] wr_offset;
    logic [DATA_W-1:0]   wr_data;
    logic                fill_done;

    assign addr_tag    = addr[ADDR_W-1 -: TAG_BITS];
    assign addr_index  = addr[OFFSET_W +: INDEX_W];
    assign addr_offset = addr[OFFSET_W-1:0];

    dcache_array #(
        .DATA_W   (DATA_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (addr_index),
        .rd_offset (addr_offset),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .wr_en     (wr_en & rst_n),
        .wr_index  (addr_index),
        .wr_offset (wr_offset),
        .wr_data   (wr_data),
        .fill_done (fill_done & rst_n),
        .fill_tag  (addr_tag)
    );

    assign hit = line_valid && (line_tag == addr_tag);

    // Next-state, stall and array-write decode; the core holds addr/wdata
    // stable while stalled, so the request address indexes every write.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        stall      = 1'b0;
        wr_en      = 1'b0;
        wr_offset  = addr_offset;
        wr_data    = wdata;
        fill_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_write) begin
                    stall   = 1'b1;
                    state_d = ST_WR_WAIT;
                end else if (mem_read && !hit) begin
                    stall   = 1'b1;
                    state_d = ST_FILL_REQ;
                end
            end
            ST_WR_WAIT: begin
                stall = !mm_gnt;
                if (mm_gnt) begin
                    wr_en   = hit;
                    state_d = ST_IDLE;
                end
            end
            ST_FILL_REQ: begin
                stall = 1'b1;
                if (mm_gnt) begin
                    fill_cnt_d = '0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                stall = 1'b1;
                if (mm_rvalid) begin
                    wr_en      = 1'b1;
                    wr_offset  = fill_cnt_q;
                    wr_data    = mm_rdata;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == LAST_WORD) begin
                        fill_done = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and fill-counter registers; reset aborts any transaction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    assign mm_req   = (state_q == ST_WR_WAIT) || (state_q == ST_FILL_REQ);
    assign mm_we    = (state_q == ST_WR_WAIT);
    assign mm_addr  = mm_we ? addr : {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign mm_wdata = wdata;

    assign rdata = (state_q == ST_IDLE && mem_read && !mem_write && hit) ? line_data : '0;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a bench-side memory and cache
// model; memory grant delay is chosen per transaction.
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        mm_req;
    logic        mm_we;
    logic [9:0]  mm_addr;
    logic [31:0] mm_wdata;
    logic        mm_gnt = 1'b0;
    logic        mm_rvalid = 1'b0;
    logic [31:0] mm_rdata = '0;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .mm_req    (mm_req),
        .mm_we     (mm_we),
        .mm_addr   (mm_addr),
        .mm_wdata  (mm_wdata),
        .mm_gnt    (mm_gnt),
        .mm_rvalid (mm_rvalid),
        .mm_rdata  (mm_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: main memory plus what the cache should currently hold
    logic [31:0] mem [1024];
    bit          mvalid [32];
    int          mtag [32];
    logic [31:0] mdata [32][4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Drive one core request and check every cycle until it retires.
    // d: mm_gnt arrives in the d-th cycle mm_req is high (d >= 1).
    // abort_words >= 0: assert reset after that many fill words.
    task automatic access(input string nm, input bit rd, input bit wr,
                          input logic [9:0] a, input logic [31:0] wd,
                          input int d, input int abort_words,
                          output logic [31:0] last_rdata, output int stall_cnt);
        int idx, off, tg, al, nk;
        bit hit, miss, exp_req, exp_stall;
        logic [31:0] exp_rd;
        idx  = int'(a[6:2]);
        off  = int'(a[1:0]);
        tg   = int'(a[9:7]);
        al   = int'({a[9:2], 2'b00});
        hit  = mvalid[idx] && (mtag[idx] == tg);
        miss = !wr && !hit;
        nk   = wr ? d : (hit ? 0 : d + 4 + 1);
        exp_rd = hit ? mdata[idx][off] : mem[int'(a)];
        stall_cnt  = 0;
        last_rdata = '0;
        for (int k = 0; k <= nk; k++) begin
            @(negedge clk);
            mem_read  = rd;
            mem_write = wr;
            addr      = a;
            wdata     = wd;
            if (miss && abort_words >= 0 && k == d + 1 + abort_words) begin
                rst_n     = 1'b0;
                mem_read  = 1'b0;
                mem_write = 1'b0;
                mm_gnt    = 1'b0;
                mm_rvalid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                chk({nm, " post-reset mm_req"}, {31'b0, mm_req}, 32'h0);
                chk({nm, " post-reset stall"}, {31'b0, stall}, 32'h0);
                chk({nm, " post-reset rdata"}, rdata, 32'h0);
                for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
                $display("txn %s addr=%h aborted by reset after %0d words", nm, a, abort_words);
                return;
            end
            mm_gnt    = (wr || miss) && (k == d);
            mm_rvalid = miss && (k >= d + 1) && (k <= d + 4);
            mm_rdata  = mm_rvalid ? mem[al + k - d - 1] : 32'h0;
            #1;
            if (stall) stall_cnt++;
            if (wr) begin
                exp_req   = (k >= 1);
                exp_stall = (k < d);
            end else if (hit) begin
                exp_req   = 1'b0;
                exp_stall = 1'b0;
            end else begin
                exp_req   = (k >= 1) && (k <= d);
                exp_stall = (k < nk);
            end
            chk($sformatf("%s k%0d stall", nm, k), {31'b0, stall}, {31'b0, exp_stall});
            chk($sformatf("%s k%0d mm_req", nm, k), {31'b0, mm_req}, {31'b0, exp_req});
            if (exp_req) begin
                chk($sformatf("%s k%0d mm_we", nm, k), {31'b0, mm_we}, {31'b0, wr});
                chk($sformatf("%s k%0d mm_addr", nm, k), {22'b0, mm_addr},
                    wr ? {22'b0, a} : al);
                if (wr) chk($sformatf("%s k%0d mm_wdata", nm, k), mm_wdata, wd);
            end
            if (!wr && k == nk) begin
                last_rdata = rdata;
                chk($sformatf("%s rdata", nm), rdata, exp_rd);
            end
        end
        if (wr) begin
            mem[int'(a)] = wd;
            if (hit) mdata[idx][off] = wd;
        end else if (miss) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            for (int j = 0; j < 4; j++) mdata[idx][j] = mem[al + j];
        end
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mm_gnt    = 1'b0;
        mm_rvalid = 1'b0;
        mm_rdata  = '0;
        #1;
        chk({nm, " idle stall"}, {31'b0, stall}, 32'h0);
        chk({nm, " idle mm_req"}, {31'b0, mm_req}, 32'h0);
        $display("txn %s rd=%0d wr=%0d addr=%h %s stall_cycles=%0d rdata=%h",
                 nm, rd, wr, a, wr ? "write" : (hit ? "hit" : "miss"), stall_cnt, last_rdata);
    endtask

    initial begin
        logic [31:0] r;
        int          sc;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        for (int j = 0; j < 4; j++) mem[16'h014 + j] = 32'hA0 + j;
        for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset stall", {31'b0, stall}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset mm_req", {31'b0, mm_req}, 32'h0);
        chk("reset mm_we", {31'b0, mm_we}, 32'h0);

        // 1: cold read miss with a 2-cycle grant
        access("t1 cold read", 1, 0, 10'h014, 0, 2, -1, r, sc);
        chk("t1 rdata literal", r, 32'hA0);
        chk("t1 stall literal", sc, 32'd7);

        // 2: neighbour word hits immediately
        access("t2 hit", 1, 0, 10'h015, 0, 1, -1, r, sc);
        chk("t2 rdata literal", r, 32'hA1);
        chk("t2 stall literal", sc, 32'd0);

        // 3: write hit then read it back
        access("t3 write", 0, 1, 10'h016, 32'hDEADBEEF, 3, -1, r, sc);
        access("t3 readback", 1, 0, 10'h016, 0, 1, -1, r, sc);
        chk("t3 rdata literal", r, 32'hDEADBEEF);

        // 4: write miss does not allocate; the following read misses
        access("t4 write miss", 0, 1, 10'h200, 32'h1234, 1, -1, r, sc);
        access("t4 read", 1, 0, 10'h200, 0, 1, -1, r, sc);
        chk("t4 rdata literal", r, 32'h1234);
        chk("t4 stall literal", sc, 32'd6);

        // 5: conflict eviction on index 5, then refetch
        access("t5 evict", 1, 0, 10'h094, 0, 2, -1, r, sc);
        access("t5 refetch", 1, 0, 10'h014, 0, 1, -1, r, sc);
        chk("t5 refetch literal", r, 32'hA0);
        chk("t5 refetch stall literal", sc, 32'd6);
        access("t5 write-through", 1, 0, 10'h016, 0, 1, -1, r, sc);
        chk("t5 write-through literal", r, 32'hDEADBEEF);

        // 6: reset mid-fill, then cold miss, then read+write collision
        access("t6 abort", 1, 0, 10'h094, 0, 1, 2, r, sc);
        access("t6 cold again", 1, 0, 10'h014, 0, 1, -1, r, sc);
        chk("t6 cold stall literal", sc, 32'd6);
        access("t6 rd+wr", 1, 1, 10'h014, 32'h55, 2, -1, r, sc);
        access("t6 after rd+wr", 1, 0, 10'h014, 0, 1, -1, r, sc);
        chk("t6 write-hit literal", r, 32'h55);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
